axi_alu_top: RTL and testbench

Streaming 4-bit ALU behind valid/ready handshakes. Each 10-bit command word enters on a write channel, is queued in an input FIFO, evaluated, and the tagged result is queued in an output FIFO for the read channel. It sits between a command producer and a result consumer, and both sides may stall independently.

---
 rtl/axi_alu_top.sv | 172 +++++++++++++++++
 tb/tb_axi_alu_top.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_alu_top.sv
// ---------------------------------------------------------------------------
// axi_alu_top
//
// Streaming 4-bit ALU behind valid/ready handshakes.
// Commands {op[1:0], a[3:0], b[3:0]} are written into an input FIFO. An
// evaluation stage moves one word per cycle from the input FIFO to the
// output FIFO, replacing the operands with the 8-bit result. The read
// channel presents the output FIFO head first-word-fall-through.
//
// Ports
//   clk     : single clock, all state on rising edge
//   reset   : synchronous active-high, flushes both FIFOs
//   wdata   : command word {op, a, b}
//   wvalid  : wdata valid
//   wready  : input FIFO not full (registered state only)
//   rvalid  : output FIFO not empty
//   rdata   : {op, res[7:0]}, forced to zero while rvalid is low
//   rready  : consumer accepts rdata
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// axi_alu_fifo
//
// Small synchronous FIFO with a combinational head read (fall-through).
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate counter.
//
// Ports
//   clk, reset : clock and synchronous active-high flush
//   push, din  : write strobe and data (ignored when full)
//   pop        : remove head (ignored when empty)
//   dout       : current head word (undefined content when empty)
//   full/empty : registered status flags
// ---------------------------------------------------------------------------
module axi_alu_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         do_push;
    logic         do_pop;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage carries no reset: stale entries are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end
endmodule

module axi_alu_top #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] wdata,
    input  logic       wvalid,
    output logic       wready,
    output logic       rvalid,
    output logic [9:0] rdata,
    input  logic       rready
);
    logic [9:0] in_head;
    logic       in_full;
    logic       in_empty;
    logic [9:0] out_head;
    logic       out_full;
    logic       out_empty;
    logic       eval_move;
    logic [9:0] eval_word;

    logic [1:0] op;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [7:0] res;

    assign wready = !in_full;
    assign rvalid = !out_empty;
    assign rdata  = out_empty ? 10'h000 : out_head;

    // Evaluation moves a word whenever there is one to take and room to
    // put it; the ALU is purely combinational so it never stalls on data.
    assign eval_move = !in_empty && !out_full;

    assign op  = in_head[9:8];
    assign opa = {4'b0000, in_head[7:4]};
    assign opb = {4'b0000, in_head[3:0]};

    always_comb begin
        res = 8'h00;
        case (op)
            2'b00:   res = opa + opb;
            2'b01:   res = opa - opb;
            2'b10:   res = opa * opb;
            default: res = opa ^ opb;
        endcase
    end

    assign eval_word = {op, res};

    axi_alu_fifo #(
        .DEPTH (IN_DEPTH),
        .W     (10)
    ) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wvalid),
        .din   (wdata),
        .pop   (eval_move),
        .dout  (in_head),
        .full  (in_full),
        .empty (in_empty)
    );

    axi_alu_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (10)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (eval_move),
        .din   (eval_word),
        .pop   (rready),
        .dout  (out_head),
        .full  (out_full),
        .empty (out_empty)
    );
endmodule

// File: tb/tb_axi_alu_top.sv
// ---------------------------------------------------------------------------
// tb_axi_alu_top
//
// Directed bench for axi_alu_top. Inputs are driven and outputs sampled
// 1 ns after each rising edge; a transfer happens at the next edge when
// the sampled valid and ready are both high.
// ---------------------------------------------------------------------------
module tb_axi_alu_top;
    logic       clk;
    logic       reset;
    logic [9:0] wdata;
    logic       wvalid;
    logic       wready;
    logic       rvalid;
    logic [9:0] rdata;
    logic       rready;

    int checks_cnt;
    int errors_cnt;

    axi_alu_top #(
        .IN_DEPTH  (4),
        .OUT_DEPTH (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wdata  (wdata),
        .wvalid (wvalid),
        .wready (wready),
        .rvalid (rvalid),
        .rdata  (rdata),
        .rready (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] alu_ref(input logic [9:0] c);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        a = {4'b0, c[7:4]};
        b = {4'b0, c[3:0]};
        case (c[9:8])
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a * b;
            default: r = a ^ b;
        endcase
        return {c[9:8], r};
    endfunction

    logic [9:0] bp_cmd [10];
    logic [9:0] bp_exp [10];
    logic [9:0] rnd_q [$];

    initial begin
        int in_idx;
        int out_idx;
        int sent;
        int got;
        logic [9:0] c;
        logic [9:0] e;

        checks_cnt = 0;
        errors_cnt = 0;
        reset  = 1'b1;
        wdata  = 10'h000;
        wvalid = 1'b1;
        rready = 1'b1;

        // Handshakes during reset must be ignored.
        tick();
        tick();
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", 32'(rdata), 32'h000);
        check("reset_wready", 32'(wready), 32'd1);
        reset  = 1'b0;
        wvalid = 1'b0;
        rready = 1'b0;
        tick();
        check("post_reset_rvalid", 32'(rvalid), 32'd0);

        // Single ADD, latency check.
        wdata = 10'h097; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("add_rvalid_n", 32'(rvalid), 32'd0);
        tick();
        check("add_rvalid_n1", 32'(rvalid), 32'd1);
        check("add_rdata", 32'(rdata), 32'h010);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("add_drained", 32'(rvalid), 32'd0);

        // SUB wrap.
        wdata = 10'h135; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        check("sub_rdata", 32'(rdata), 32'h1FE);
        rready = 1'b1;
        tick();
        check("sub_drained", 32'(rvalid), 32'd0);

        // MUL then XOR back to back, rready held high.
        wdata = 10'h2FF; wvalid = 1'b1;
        tick();
        check("mx_rvalid_first", 32'(rvalid), 32'd0);
        wdata = 10'h3A5;
        tick();
        wvalid = 1'b0;
        check("mx_mul_rvalid", 32'(rvalid), 32'd1);
        check("mx_mul_rdata", 32'(rdata), 32'h2E1);
        tick();
        check("mx_xor_rvalid", 32'(rvalid), 32'd1);
        check("mx_xor_rdata", 32'(rdata), 32'h30F);
        tick();
        check("mx_drained", 32'(rvalid), 32'd0);
        rready = 1'b0;

        // Backpressure: 10 commands, read side stalled.
        bp_cmd[0] = 10'h000; bp_exp[0] = 10'h000;
        bp_cmd[1] = 10'h0FF; bp_exp[1] = 10'h01E;
        bp_cmd[2] = 10'h1F0; bp_exp[2] = 10'h10F;
        bp_cmd[3] = 10'h10F; bp_exp[3] = 10'h1F1;
        bp_cmd[4] = 10'h255; bp_exp[4] = 10'h219;
        bp_cmd[5] = 10'h2F0; bp_exp[5] = 10'h200;
        bp_cmd[6] = 10'h3FF; bp_exp[6] = 10'h300;
        bp_cmd[7] = 10'h30F; bp_exp[7] = 10'h30F;
        bp_cmd[8] = 10'h212; bp_exp[8] = 10'h202;
        bp_cmd[9] = 10'h1A3; bp_exp[9] = 10'h107;

        in_idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            wvalid = 1'b1;
            wdata  = bp_cmd[in_idx];
            if (wready) in_idx++;
            tick();
        end
        check("bp_accepted", 32'(in_idx), 32'd8);
        check("bp_wready_low", 32'(wready), 32'd0);

        out_idx = 0;
        for (int cyc = 0; cyc < 200 && out_idx < 10; cyc++) begin
            wvalid = (in_idx < 10);
            wdata  = (in_idx < 10) ? bp_cmd[in_idx] : 10'h000;
            rready = cyc[0];
            if (rvalid) begin
                check($sformatf("bp_result%0d", out_idx), 32'(rdata), 32'(bp_exp[out_idx]));
                if (rready) out_idx++;
            end
            if (wvalid && wready) in_idx++;
            tick();
        end
        wvalid = 1'b0;
        rready = 1'b0;
        check("bp_all_accepted", 32'(in_idx), 32'd10);
        check("bp_all_returned", 32'(out_idx), 32'd10);
        tick();
        check("bp_drained", 32'(rvalid), 32'd0);

        // Reset mid-operation with 3 results queued.
        for (int k = 0; k < 3; k++) begin
            wdata = 10'h011 + 10'(k); wvalid = 1'b1;
            tick();
        end
        wvalid = 1'b0;
        tick();
        tick();
        check("mr_queued", 32'(rvalid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_rvalid", 32'(rvalid), 32'd0);
        check("mr_rdata", 32'(rdata), 32'h000);
        check("mr_wready", 32'(wready), 32'd1);
        rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("mr_stays_empty%0d", k), 32'(rvalid), 32'd0);
        end

        // Simultaneous traffic: 20 random commands, both sides free-running.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
            wvalid = (sent < 20);
            c = 10'($urandom_range(0, 1023));
            wdata = c;
            if (got > 0) check($sformatf("st_nogap%0d", got), 32'(rvalid), 32'd1);
            if (rvalid && rready) begin
                e = rnd_q.pop_front();
                check($sformatf("st_result%0d", got), 32'(rdata), 32'(e));
                got++;
            end
            if (wvalid && wready) begin
                rnd_q.push_back(alu_ref(c));
                sent++;
            end
            tick();
        end
        wvalid = 1'b0;
        check("st_returned", 32'(got), 32'd20);
        tick();
        check("st_drained", 32'(rvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
